alu_mdu: RTL and testbench

//   Parametrised, registered multi-cycle ALU for the multi-cycle CPU datapath. Executes

---
 rtl/alu_mdu.sv | 271 +++++++++++++++++++++++++++
 tb/tb_alu_mdu.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: registered multi-cycle ALU for the EX stage.
// Single-cycle logic/arith/shift ops complete one edge after issue. MULT/MULTU use
// an iterative shift-add multiplier, and DIV/DIVU a restoring divider, writing HI/LO.
// Optional feature macro: ALU_MDU_DIV_EN builds the divider. Without it, DIV/DIVU
// take one FSM pass through FIX with result=0 and HI/LO left untouched.
module alu_mdu #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_SLT  = 4'h5;
   localparam logic [3:0] OP_SLTU = 4'h6;
   localparam logic [3:0] OP_NOR  = 4'h7;
   localparam logic [3:0] OP_SLL  = 4'h8;
   localparam logic [3:0] OP_SRL  = 4'h9;
   localparam logic [3:0] OP_SRA  = 4'hA;
   localparam logic [3:0] OP_MULT = 4'hB;
   localparam logic [3:0] OP_MULTU= 4'hC;
   localparam logic [3:0] OP_DIV  = 4'hD;
   localparam logic [3:0] OP_DIVU = 4'hE;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t               state_q, state_d;
   logic [SHW-1:0]       cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 zero_q, zero_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   // Iteration datapath: acc holds {upper, lower} of product or {remainder, quotient}
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opd_q, opd_d;      // multiplicand or divisor magnitude
   logic                 neg_lo_q, neg_lo_d; // negate product / quotient at FIX
   logic                 skip_q, skip_d;     // complete at FIX without iterating
`ifdef ALU_MDU_DIV_EN
   logic                 is_div_q, is_div_d;
   logic                 neg_hi_q, neg_hi_d; // remainder follows dividend sign
   logic [WIDTH-1:0]     araw_q, araw_d;     // raw dividend for divide-by-zero HI
   logic [WIDTH:0]       div_tmp;
   logic                 div_ge;
   logic [WIDTH-1:0]     div_rem;
   logic [2*WIDTH-1:0]   div_next;
`endif

   logic [WIDTH-1:0]     alu_res;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [2*WIDTH-1:0]   prod_fix;
   logic                 sgn_a, sgn_b;

   // Absolute value when the operand is treated as signed.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                  input logic             is_signed);
      return (is_signed && x[WIDTH-1]) ? -x : x;
   endfunction

   // Conditional two's-complement negation.
   function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] x,
                                                  input logic             neg);
      return neg ? -x : x;
   endfunction

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign zero   = zero_q;
   assign hi     = hi_q;
   assign lo     = lo_q;

   // Single-cycle operation result from the live operands.
   always_comb begin
      alu_res = a;
      case (op)
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
         OP_NOR:  alu_res = ~(a | b);
         OP_SLL:  alu_res = b << shamt;
         OP_SRL:  alu_res = b >> shamt;
         OP_SRA:  alu_res = $signed(b) >>> shamt;
         default: alu_res = a;
      endcase
   end

   // One shift-add multiply step and the signed product fix-up.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      prod_fix = neg_lo_q ? -acc_q : acc_q;
   end

`ifdef ALU_MDU_DIV_EN
   // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge   = (div_tmp >= {1'b0, opd_q});
      div_rem  = div_ge ? WIDTH'(div_tmp - {1'b0, opd_q}) : div_tmp[WIDTH-1:0];
      div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};
   end
`endif

   // Next-state and next-output logic for the IDLE -> CALC -> FIX sequence.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      zero_d   = zero_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      acc_d    = acc_q;
      opd_d    = opd_q;
      neg_lo_d = neg_lo_q;
      skip_d   = skip_q;
`ifdef ALU_MDU_DIV_EN
      is_div_d = is_div_q;
      neg_hi_d = neg_hi_q;
      araw_d   = araw_q;
`endif
      sgn_a    = 1'b0;
      sgn_b    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     sgn_a    = (op == OP_MULT) && a[WIDTH-1];
                     sgn_b    = (op == OP_MULT) && b[WIDTH-1];
                     acc_d    = {{WIDTH{1'b0}}, magnitude(b, op == OP_MULT)};
                     opd_d    = magnitude(a, op == OP_MULT);
                     neg_lo_d = sgn_a ^ sgn_b;
                     skip_d   = 1'b0;
`ifdef ALU_MDU_DIV_EN
                     is_div_d = 1'b0;
`endif
                     cnt_d    = '0;
                     busy_d   = 1'b1;
                     state_d  = S_CALC;
                  end
                  OP_DIV, OP_DIVU: begin
`ifdef ALU_MDU_DIV_EN
                     sgn_a    = (op == OP_DIV) && a[WIDTH-1];
                     sgn_b    = (op == OP_DIV) && b[WIDTH-1];
                     acc_d    = {{WIDTH{1'b0}}, magnitude(a, op == OP_DIV)};
                     opd_d    = magnitude(b, op == OP_DIV);
                     neg_lo_d = sgn_a ^ sgn_b;
                     neg_hi_d = sgn_a;
                     is_div_d = 1'b1;
                     araw_d   = a;
                     skip_d   = (b == '0);
                     cnt_d    = '0;
                     busy_d   = 1'b1;
                     state_d  = (b == '0) ? S_FIX : S_CALC;
`else
                     skip_d   = 1'b1;
                     busy_d   = 1'b1;
                     state_d  = S_FIX;
`endif
                  end
                  default: begin
                     result_d = alu_res;
                     zero_d   = (alu_res == '0);
                     done_d   = 1'b1;
                  end
               endcase
            end
         end
         S_CALC: begin
`ifdef ALU_MDU_DIV_EN
            acc_d = is_div_q ? div_next : mul_next;
`else
            acc_d = mul_next;
`endif
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == SHW'(WIDTH-1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (skip_q) begin
`ifdef ALU_MDU_DIV_EN
               hi_d     = araw_q;
               lo_d     = '1;
               result_d = '1;
               zero_d   = 1'b0;
`else
               result_d = '0;
               zero_d   = 1'b1;
`endif
            end
`ifdef ALU_MDU_DIV_EN
            else if (is_div_q) begin
               lo_d     = negate_if(acc_q[WIDTH-1:0], neg_lo_q);
               hi_d     = negate_if(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
               result_d = negate_if(acc_q[WIDTH-1:0], neg_lo_q);
               zero_d   = (acc_q[WIDTH-1:0] == '0);
            end
`endif
            else begin
               hi_d     = prod_fix[2*WIDTH-1:WIDTH];
               lo_d     = prod_fix[WIDTH-1:0];
               result_d = prod_fix[WIDTH-1:0];
               zero_d   = (prod_fix[WIDTH-1:0] == '0);
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and architectural output registers; reset aborts any operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b1;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   // Iteration datapath registers; only meaningful while the FSM is out of IDLE.
   always_ff @(posedge clk) begin
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      neg_lo_q <= neg_lo_d;
      skip_q   <= skip_d;
`ifdef ALU_MDU_DIV_EN
      is_div_q <= is_div_d;
      neg_hi_q <= neg_hi_d;
      araw_q   <= araw_d;
`endif
   end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: self-checking bench for alu_mdu (WIDTH=32) with a behavioural model.
`timescale 1ns/1ps
module tb_alu_mdu;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic [4:0]  shamt;
   logic        busy, done, zero;
   logic [31:0] result, hi, lo;

   int errors = 0;
   int checks = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   always #5 clk = ~clk;

   alu_mdu #(.WIDTH(32), .SHW(5)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .shamt(shamt),
      .busy(busy), .done(done), .result(result), .zero(zero), .hi(hi), .lo(lo)
   );

   // Behavioural model: result, HI/LO and edges from issue to done.
   function automatic void model(input logic [3:0] mop, input logic [31:0] ma, mb,
                                 input logic [4:0] msh, inout logic [31:0] mhi, mlo,
                                 output logic [31:0] mres, output int lat);
      logic [63:0] p;
      longint sa, sb, q, r;
      lat  = 0;
      mres = ma;
      case (mop)
         4'h1: mres = ma + mb;
         4'h2: mres = ma - mb;
         4'h3: mres = ma & mb;
         4'h4: mres = ma | mb;
         4'h5: mres = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
         4'h6: mres = (ma < mb) ? 32'd1 : 32'd0;
         4'h7: mres = ~(ma | mb);
         4'h8: mres = mb << msh;
         4'h9: mres = mb >> msh;
         4'hA: mres = $signed(mb) >>> msh;
         4'hB, 4'hC: begin
            if (mop == 4'hB) p = 64'(longint'($signed(ma)) * longint'($signed(mb)));
            else             p = {32'd0, ma} * {32'd0, mb};
            mhi = p[63:32]; mlo = p[31:0]; mres = mlo; lat = 33;
         end
         4'hD, 4'hE: begin
`ifdef ALU_MDU_DIV_EN
            if (mb == 32'd0) begin
               mhi = ma; mlo = 32'hFFFFFFFF; mres = mlo; lat = 1;
            end else begin
               if (mop == 4'hD) begin
                  sa = longint'($signed(ma)); sb = longint'($signed(mb));
               end else begin
                  sa = longint'({32'd0, ma}); sb = longint'({32'd0, mb});
               end
               q = sa / sb; r = sa % sb;
               mlo = q[31:0]; mhi = r[31:0]; mres = mlo; lat = 33;
            end
`else
            mres = 32'd0; lat = 1;
`endif
         end
         default: mres = ma;
      endcase
   endfunction

   // Issue one op and wait (bounded) for done; operands are scrambled after issue.
   task automatic issue_wait(input logic [3:0] o, input logic [31:0] x, y,
                             input logic [4:0] s, output int lat, output bit got);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y; shamt = s;
      @(posedge clk); #1;
      start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
      lat = 0; got = done;
      while (!got && lat < 60) begin
         @(posedge clk); #1;
         lat++; got = done;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
      checks++; if (zero !== 1'b1)    begin errors++; $display("FAIL reset_zero got %b want 1", zero); end
      checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_single();
      logic [3:0]  d_op [10] = '{4'h1, 4'h2, 4'h5, 4'h6, 4'hA, 4'h7, 4'h8, 4'h9, 4'h0, 4'hF};
      logic [31:0] d_a  [10] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,
                                 32'hF0F00000, 32'd0, 32'd0, 32'h12345678, 32'hCAFEBABE};
      logic [31:0] d_b  [10] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h80000000,
                                 32'h0000F0F0, 32'h00000001, 32'h80000000, 32'd9, 32'd3};
      logic [4:0]  d_sh [10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd31, 5'd31, 5'd0, 5'd0};
      logic [3:0]  o;
      logic [31:0] x, y, r_e;
      logic [4:0]  s;
      int lat, lat_e;
      bit got;
      for (int i = 0; i < 50; i++) begin
         if (i < 10) begin
            o = d_op[i]; x = d_a[i]; y = d_b[i]; s = d_sh[i];
         end else begin
            o = 4'($urandom_range(0, 11)); if (o == 4'd11) o = 4'hF;
            x = $urandom; y = $urandom; s = 5'($urandom);
         end
         model(o, x, y, s, m_hi, m_lo, r_e, lat_e);
         issue_wait(o, x, y, s, lat, got);
         checks++;
         if (!got) begin
            errors++; $display("FAIL single_timeout op=%h got no done want done", o);
         end else begin
            checks++; if (lat !== lat_e) begin errors++; $display("FAIL single_lat op=%h got %0d want %0d", o, lat, lat_e); end
            checks++; if (result !== r_e) begin errors++; $display("FAIL single_result op=%h a=%h b=%h got %h want %h", o, x, y, result, r_e); end
            checks++; if (zero !== (r_e == 32'd0)) begin errors++; $display("FAIL single_zero op=%h got %b want %b", o, zero, r_e == 32'd0); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy op=%h got %b want 0", o, busy); end
            checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL single_hilo op=%h got %h/%h want %h/%h", o, hi, lo, m_hi, m_lo); end
         end
      end
   endtask

   task automatic test_mult();
      logic [3:0]  d_op [5] = '{4'hB, 4'hC, 4'hB, 4'hB, 4'hC};
      logic [31:0] d_a  [5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
      logic [31:0] d_b  [5] = '{32'd3, 32'd3, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [3:0]  o;
      logic [31:0] x, y, r_e;
      int lat, lat_e;
      bit got;
      for (int i = 0; i < 11; i++) begin
         if (i < 5) begin o = d_op[i]; x = d_a[i]; y = d_b[i]; end
         else begin o = ($urandom_range(0, 1) == 0) ? 4'hB : 4'hC; x = $urandom; y = $urandom; end
         model(o, x, y, 5'd0, m_hi, m_lo, r_e, lat_e);
         issue_wait(o, x, y, 5'd0, lat, got);
         checks++;
         if (!got) begin
            errors++; $display("FAIL mult_timeout op=%h got no done want done", o);
         end else begin
            checks++; if (lat !== lat_e) begin errors++; $display("FAIL mult_lat op=%h got %0d want %0d", o, lat, lat_e); end
            checks++; if (hi !== m_hi) begin errors++; $display("FAIL mult_hi op=%h a=%h b=%h got %h want %h", o, x, y, hi, m_hi); end
            checks++; if (lo !== m_lo) begin errors++; $display("FAIL mult_lo op=%h a=%h b=%h got %h want %h", o, x, y, lo, m_lo); end
            checks++; if (result !== r_e || zero !== (r_e == 32'd0)) begin errors++; $display("FAIL mult_result op=%h got %h/%b want %h", o, result, zero, r_e); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy got %b want 0", busy); end
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b want 0", done); end
         end
      end
   endtask

   task automatic test_div();
      logic [3:0]  d_op [6] = '{4'hD, 4'hD, 4'hD, 4'hE, 4'hD, 4'hE};
      logic [31:0] d_a  [6] = '{32'hFFFFFFF9, 32'd9, 32'h80000000, 32'hFFFFFFF9, 32'd7, 32'd100};
      logic [31:0] d_b  [6] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd0};
      logic [3:0]  o;
      logic [31:0] x, y, r_e;
      int lat, lat_e;
      bit got;
      for (int i = 0; i < 12; i++) begin
         if (i < 6) begin o = d_op[i]; x = d_a[i]; y = d_b[i]; end
         else begin
            o = ($urandom_range(0, 1) == 0) ? 4'hD : 4'hE;
            x = $urandom;
            case ($urandom_range(0, 2))
               0:       y = 32'd0;
               1:       y = $urandom_range(1, 100);
               default: y = $urandom;
            endcase
         end
         model(o, x, y, 5'd0, m_hi, m_lo, r_e, lat_e);
         issue_wait(o, x, y, 5'd0, lat, got);
         checks++;
         if (!got) begin
            errors++; $display("FAIL div_timeout op=%h got no done want done", o);
         end else begin
            checks++; if (lat !== lat_e) begin errors++; $display("FAIL div_lat op=%h b=%h got %0d want %0d", o, y, lat, lat_e); end
            checks++; if (hi !== m_hi) begin errors++; $display("FAIL div_hi op=%h a=%h b=%h got %h want %h", o, x, y, hi, m_hi); end
            checks++; if (lo !== m_lo) begin errors++; $display("FAIL div_lo op=%h a=%h b=%h got %h want %h", o, x, y, lo, m_lo); end
            checks++; if (result !== r_e || zero !== (r_e == 32'd0)) begin errors++; $display("FAIL div_result op=%h got %h/%b want %h", o, result, zero, r_e); end
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL div_done_pulse got %b want 0", done); end
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] x, y, r_e, r_got, h_got, l_got;
      int lat_e, ndone, lat_got;
      x = $urandom; y = $urandom;
      model(4'hC, x, y, 5'd0, m_hi, m_lo, r_e, lat_e);
      @(negedge clk); start = 1'b1; op = 4'hC; a = x; b = y; shamt = '0;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0; lat_got = -1; r_got = '0; h_got = '0; l_got = '0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         start = (i == 10); op = 4'h1; a = 32'd2; b = 32'd3;
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            if (lat_got < 0) begin lat_got = i + 1; r_got = result; h_got = hi; l_got = lo; end
         end
      end
      start = 1'b0;
      checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_ignore_count got %0d want 1", ndone); end
      checks++; if (lat_got !== lat_e) begin errors++; $display("FAIL busy_ignore_lat got %0d want %0d", lat_got, lat_e); end
      checks++; if (r_got !== r_e || h_got !== m_hi || l_got !== m_lo) begin
         errors++; $display("FAIL busy_ignore_value got %h %h/%h want %h %h/%h", r_got, h_got, l_got, r_e, m_hi, m_lo);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] x, y, r_e, r32, r33, h33, l33, add_e;
      logic d32, d33;
      int lat_e, early;
      x = $urandom; y = $urandom;
      model(4'hB, x, y, 5'd0, m_hi, m_lo, r_e, lat_e);
      model(4'h1, 32'd2, 32'd3, 5'd0, m_hi, m_lo, add_e, lat_e);
      @(negedge clk); start = 1'b1; op = 4'hB; a = x; b = y; shamt = '0;
      @(posedge clk); #1;
      early = 0; d32 = 1'b0; d33 = 1'b0; r32 = '0; r33 = '0; h33 = '0; l33 = '0;
      for (int i = 0; i < 34; i++) begin
         @(negedge clk); start = 1'b1; op = 4'h1; a = 32'd2; b = 32'd3;
         @(posedge clk); #1;
         if (i < 32 && done) early++;
         if (i == 32) begin d32 = done; r32 = result; end
         if (i == 33) begin d33 = done; r33 = result; h33 = hi; l33 = lo; end
      end
      start = 1'b0;
      checks++; if (early !== 0) begin errors++; $display("FAIL b2b_early_done got %0d want 0", early); end
      checks++; if (d32 !== 1'b1 || r32 !== r_e) begin errors++; $display("FAIL b2b_mult got done=%b %h want 1 %h", d32, r32, r_e); end
      checks++; if (d33 !== 1'b1 || r33 !== add_e) begin errors++; $display("FAIL b2b_add got done=%b %h want 1 %h", d33, r33, add_e); end
      checks++; if (h33 !== m_hi || l33 !== m_lo) begin errors++; $display("FAIL b2b_hilo got %h/%h want %h/%h", h33, l33, m_hi, m_lo); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r_e;
      int lat, lat_e, ndone;
      bit got;
      @(negedge clk); start = 1'b1; op = 4'hC; a = $urandom; b = $urandom; shamt = '0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      @(negedge clk); rst = 1'b1; #1;
      m_hi = '0; m_lo = '0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
      checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rstmid_hilo got %h/%h want 0/0", hi, lo); end
      checks++; if (zero !== 1'b1 || result !== 32'd0) begin errors++; $display("FAIL rstmid_result got %h/%b want 0/1", result, zero); end
      @(negedge clk); rst = 1'b0;
      ndone = 0;
      repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
      checks++; if (ndone !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got %0d dones busy=%b want 0", ndone, busy); end
      model(4'h1, 32'd2, 32'd3, 5'd0, m_hi, m_lo, r_e, lat_e);
      issue_wait(4'h1, 32'd2, 32'd3, 5'd0, lat, got);
      checks++; if (!got || lat !== lat_e || result !== r_e) begin
         errors++; $display("FAIL rstmid_add got done=%b lat=%0d %h want lat=%0d %h", got, lat, result, lat_e, r_e);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_mult();
      test_div();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
